// File: rtl/irq_controller.sv
// irq_controller: parametrised interrupt controller for the Sol-1 CPU.
// It synchronises the external IRQ pins and supports edge or level mode per
// channel. Channel 0 has the highest priority. The interrupt vector is
// VEC_BASE + (idx << VEC_SHIFT).
// Optional feature macro IRQ_NESTING_EN adds the in-service register, EOI
// handling and priority blocking behind the highest in-service channel.
module irq_controller #(
  parameter int unsigned NUM_IRQ     = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned VEC_BASE    = 0,
  parameter int unsigned VEC_SHIFT   = 1
) (
  input  logic               arst,
  input  logic               clk,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_wr,
  input  logic               mode_wr,
  input  logic [NUM_IRQ-1:0] wdata,
  input  logic               int_enable,
  input  logic               vector_latch,
  input  logic               int_ack,
  input  logic               eoi,
  input  logic               clear_all,
  output logic               int_pending,
  output logic [7:0]         irq_vector,
  output logic [NUM_IRQ-1:0] irq_status,
  output logic [NUM_IRQ-1:0] irq_masks,
  output logic [NUM_IRQ-1:0] in_service
);

  localparam int unsigned IDX_W = $clog2(NUM_IRQ);

  if (NUM_IRQ < 2 || NUM_IRQ > 16) begin : g_chk_num
    $error("irq_controller: NUM_IRQ must be in 2..16");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("irq_controller: SYNC_STAGES must be >= 2");
  end
  if (VEC_BASE + ((NUM_IRQ - 1) << VEC_SHIFT) > 255) begin : g_chk_vec
    $error("irq_controller: highest vector exceeds 255");
  end

  // Lowest set index; channel 0 is the highest priority.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_IRQ-1:0] v);
    logic found;
    lowest_set = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (!found && v[i]) begin
        found      = 1'b1;
        lowest_set = IDX_W'(i);
      end
    end
  endfunction

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] prev_q;
  logic [NUM_IRQ-1:0] sync_s;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mode_q;
  logic [NUM_IRQ-1:0] ack_onehot, edge_set, edge_next;
  logic [NUM_IRQ-1:0] prio_ok, serviceable;
  logic [IDX_W-1:0]   latched_idx_q, serv_idx_d;
  logic [7:0]         irq_vector_q, vec_d;
  logic               int_pending_q;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain plus one-cycle history for edge detection.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev_q <= sync_s;
    end
  end

  // Pending next state: a new edge beats an ack, and clear_all beats a new edge.
  // Level channels follow the synchronised input directly.
  always_comb begin
    ack_onehot = int_ack ? (NUM_IRQ'(1) << latched_idx_q) : '0;
    edge_set   = sync_s & ~prev_q;
    edge_next  = clear_all ? '0 : (edge_set | (pending_q & ~ack_onehot));
    pending_d  = (mode_q & sync_s) | (~mode_q & edge_next);
  end

`ifdef IRQ_NESTING_EN
  logic [NUM_IRQ-1:0] in_service_q, in_service_d;

  // In-service update: the EOI clear is applied before the ack set; clear_all overrides both.
  always_comb begin
    in_service_d = in_service_q;
    if (eoi && |in_service_q) in_service_d[lowest_set(in_service_q)] = 1'b0;
    if (int_ack) in_service_d[latched_idx_q] = 1'b1;
    if (clear_all) in_service_d = '0;
  end

  // Only channels strictly above the highest-priority in-service channel may be served.
  always_comb begin
    logic blocked;
    blocked = 1'b0;
    prio_ok = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      blocked    = blocked | in_service_q[i];
      prio_ok[i] = ~blocked;
    end
  end

  // In-service register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) in_service_q <= '0;
    else      in_service_q <= in_service_d;
  end

  assign in_service = in_service_q;
`else
  logic unused_eoi;
  assign unused_eoi = eoi;
  assign prio_ok    = '1;
  assign in_service = '0;
`endif

  assign serviceable = pending_q & mask_q & prio_ok;
  assign serv_idx_d  = lowest_set(serviceable);
  assign vec_d       = 8'(VEC_BASE + (32'(serv_idx_d) << VEC_SHIFT));

  // Pending, mask/mode, request and vector registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pending_q     <= '0;
      mask_q        <= '0;
      mode_q        <= '0;
      int_pending_q <= 1'b0;
      latched_idx_q <= '0;
      irq_vector_q  <= '0;
    end else begin
      pending_q     <= pending_d;
      int_pending_q <= int_enable & (|serviceable);
      if (mask_wr) mask_q <= wdata;
      if (mode_wr) mode_q <= wdata;
      if (vector_latch && (|serviceable)) begin
        latched_idx_q <= serv_idx_d;
        irq_vector_q  <= vec_d;
      end
    end
  end

  assign int_pending = int_pending_q;
  assign irq_vector  = irq_vector_q;
  assign irq_status  = pending_q;
  assign irq_masks   = mask_q;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed and random stimulus for irq_controller, checked
// against a cycle-level behavioural model of the controller's rules.
module tb_irq_controller;

  localparam int N  = 8;
  localparam int SS = 2;
  localparam int VB = 0;
  localparam int VS = 1;
`ifdef IRQ_NESTING_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic         arst, clk;
  logic [N-1:0] irq_in, wdata;
  logic         mask_wr, mode_wr, int_enable, vector_latch, int_ack, eoi, clear_all;
  logic         int_pending;
  logic [7:0]   irq_vector;
  logic [N-1:0] irq_status, irq_masks, in_service;

  irq_controller #(.NUM_IRQ(N), .SYNC_STAGES(SS), .VEC_BASE(VB), .VEC_SHIFT(VS)) dut (
    .arst(arst), .clk(clk), .irq_in(irq_in), .mask_wr(mask_wr), .mode_wr(mode_wr),
    .wdata(wdata), .int_enable(int_enable), .vector_latch(vector_latch),
    .int_ack(int_ack), .eoi(eoi), .clear_all(clear_all), .int_pending(int_pending),
    .irq_vector(irq_vector), .irq_status(irq_status), .irq_masks(irq_masks),
    .in_service(in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk, nerr;

  // Reference model state.
  logic [N-1:0] hist[$];   // irq_in samples, newest first
  logic [N-1:0] m_pend, m_mask, m_mode, m_isv;
  logic         m_ip;
  int           m_vec, m_idx;

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k <= SS; k++) hist.push_back('0);
    m_pend = '0; m_mask = '0; m_mode = '0; m_isv = '0;
    m_ip = 1'b0; m_vec = 0; m_idx = 0;
  endtask

  // One clock edge of the model, using the inputs present before the edge.
  task automatic model_edge();
    logic [N-1:0] s, p, np, ni;
    int top, low;
    s = hist[SS-1];
    p = hist[SS];
    top = N;
    for (int i = N - 1; i >= 0; i--) if (m_isv[i]) top = i;
    low = -1;
    for (int i = 0; i < N; i++)
      if (low < 0 && m_pend[i] && m_mask[i] && (!NEST || i < top)) low = i;
    for (int i = 0; i < N; i++) begin
      if (m_mode[i])                   np[i] = s[i];
      else if (clear_all)              np[i] = 1'b0;
      else if (s[i] && !p[i])          np[i] = 1'b1;
      else if (int_ack && m_idx == i)  np[i] = 1'b0;
      else                             np[i] = m_pend[i];
    end
    ni = m_isv;
    if (NEST) begin
      if (eoi && top < N) ni[top] = 1'b0;
      if (int_ack) ni[m_idx] = 1'b1;
      if (clear_all) ni = '0;
    end
    m_ip = int_enable && (low >= 0);
    if (vector_latch && low >= 0) begin
      m_idx = low;
      m_vec = (VB + low * (1 << VS)) % 256;
    end
    if (mask_wr) m_mask = wdata;
    if (mode_wr) m_mode = wdata;
    m_pend = np;
    m_isv  = ni;
    hist.push_front(irq_in);
    void'(hist.pop_back());
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("int_pending", 32'(int_pending), 32'(m_ip));
    check("irq_vector",  32'(irq_vector),  32'(m_vec));
    check("irq_status",  32'(irq_status),  32'(m_pend));
    check("irq_masks",   32'(irq_masks),   32'(m_mask));
    check("in_service",  32'(in_service),  32'(m_isv));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    #2 arst = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("rst_all_zero", 32'({int_pending, irq_vector, irq_status, irq_masks, in_service}), 32'd0);
    arst = 1'b0;
  endtask

  initial begin
    nchk = 0; nerr = 0;
    arst = 1'b1; irq_in = '0; wdata = '0; mask_wr = 0; mode_wr = 0; int_enable = 0;
    vector_latch = 0; int_ack = 0; eoi = 0; clear_all = 0;
    model_reset();
    #3;
    compare_all();
    arst = 1'b0;
    int_enable = 1'b1;

    // Single edge on channel 3 through to ack.
    mask_wr = 1; wdata = 8'h08; tick(); mask_wr = 0;
    check("t1_mask", 32'(irq_masks), 32'h08);
    irq_in[3] = 1'b1;
    ticks(3);
    check("t1_status_e3", 32'(irq_status[3]), 32'd1);
    check("t1_ip_e3", 32'(int_pending), 32'd0);
    tick();
    check("t1_ip_e4", 32'(int_pending), 32'd1);
    vector_latch = 1; tick(); vector_latch = 0;
    check("t1_vec", 32'(irq_vector), 32'h06);
    int_ack = 1; tick(); int_ack = 0;
    check("t1_status_ack", 32'(irq_status[3]), 32'd0);
    eoi = 1; tick(); eoi = 0;
    check("t1_ip_after", 32'(int_pending), 32'd0);
    irq_in[3] = 1'b0; ticks(3);

    // Two simultaneous requests, priority order.
    mask_wr = 1; wdata = 8'hFF; tick(); mask_wr = 0;
    irq_in[5] = 1'b1; irq_in[2] = 1'b1; ticks(3);
    vector_latch = 1; tick(); vector_latch = 0;
    check("t2_vec_a", 32'(irq_vector), 32'h04);
    int_ack = 1; tick(); int_ack = 0;
    check("t2_status", 32'(irq_status & 8'h24), 32'h20);
    eoi = 1; tick(); eoi = 0;
    vector_latch = 1; tick(); vector_latch = 0;
    check("t2_vec_b", 32'(irq_vector), 32'h0A);
    int_ack = 1; tick(); int_ack = 0;
    eoi = 1; tick(); eoi = 0;
    irq_in = '0; ticks(3);

    // Level mode on channel 1.
    mode_wr = 1; wdata = 8'h02; tick(); mode_wr = 0;
    irq_in[1] = 1'b1; ticks(3);
    check("t3_status_lvl", 32'(irq_status[1]), 32'd1);
    vector_latch = 1; tick(); vector_latch = 0;
    check("t3_vec", 32'(irq_vector), 32'h02);
    int_ack = 1; tick(); int_ack = 0;
    check("t3_ack_noclr", 32'(irq_status[1]), 32'd1);
    eoi = 1; tick(); eoi = 0;
    irq_in[1] = 1'b0; ticks(2);
    check("t3_drop_2", 32'(irq_status[1]), 32'd1);
    tick();
    check("t3_drop_3", 32'(irq_status[1]), 32'd0);
    mode_wr = 1; wdata = 8'h00; tick(); mode_wr = 0;

    // Edge colliding with clear_all, then with ack.
    irq_in[4] = 1'b1; ticks(2);
    clear_all = 1; tick(); clear_all = 0;
    check("t4_clr_wins", 32'(irq_status[4]), 32'd0);
    tick();
    check("t4_clr_hold", 32'(irq_status[4]), 32'd0);
    irq_in[4] = 1'b0; ticks(3);
    irq_in[4] = 1'b1; ticks(3);
    check("t4_pend", 32'(irq_status[4]), 32'd1);
    vector_latch = 1; tick(); vector_latch = 0;
    check("t4_vec", 32'(irq_vector), 32'h08);
    irq_in[4] = 1'b0; ticks(2);
    irq_in[4] = 1'b1; ticks(2);
    int_ack = 1; tick(); int_ack = 0;
    check("t4_edge_ack", 32'(irq_status[4]), 32'd1);
    clear_all = 1; tick(); clear_all = 0;
    check("t4_clear", 32'(irq_status), 32'd0);
    irq_in[4] = 1'b0; ticks(3);

`ifdef IRQ_NESTING_EN
    // Nested service: ch3 in service blocks ch5 but not ch1.
    irq_in[3] = 1'b1; ticks(3);
    vector_latch = 1; tick(); vector_latch = 0;
    int_ack = 1; tick(); int_ack = 0;
    check("n_isv3", 32'(in_service), 32'h08);
    irq_in[5] = 1'b1; ticks(4);
    check("n_ch5_blocked", 32'(int_pending), 32'd0);
    irq_in[1] = 1'b1; ticks(4);
    check("n_ch1_pass", 32'(int_pending), 32'd1);
    vector_latch = 1; tick(); vector_latch = 0;
    check("n_vec1", 32'(irq_vector), 32'h02);
    int_ack = 1; tick(); int_ack = 0;
    check("n_isv_0a", 32'(in_service), 32'h0A);
    eoi = 1; tick();
    check("n_eoi1", 32'(in_service), 32'h08);
    tick(); eoi = 0;
    check("n_eoi2", 32'(in_service), 32'h00);
    vector_latch = 1; tick(); vector_latch = 0;
    check("n_vec5", 32'(irq_vector), 32'h0A);
    int_ack = 1; tick();
    check("n_isv5", 32'(in_service), 32'h20);
    eoi = 1; tick(); int_ack = 0;
    check("n_eoi_then_set", 32'(in_service), 32'h20);
    tick(); eoi = 0;
    check("n_isv_clear", 32'(in_service), 32'h00);
    irq_in = '0; ticks(3);
`endif

    // Masked pending, global enable, then async reset.
    mask_wr = 1; wdata = 8'h00; tick(); mask_wr = 0;
    irq_in[6] = 1'b1; ticks(4);
    check("t6_status", 32'(irq_status[6]), 32'd1);
    check("t6_masked_ip", 32'(int_pending), 32'd0);
    mask_wr = 1; wdata = 8'h40; tick(); mask_wr = 0;
    int_enable = 0; ticks(2);
    check("t6_disabled_ip", 32'(int_pending), 32'd0);
    int_enable = 1; tick();
    check("t6_enabled_ip", 32'(int_pending), 32'd1);
    async_reset();
    ticks(4);

    // Random phase.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) irq_in[i] = ~irq_in[i];
      mask_wr      = ($urandom_range(15) == 0);
      mode_wr      = ($urandom_range(15) == 0);
      wdata        = N'($urandom);
      int_enable   = ($urandom_range(9) != 0);
      vector_latch = ($urandom_range(3) == 0);
      int_ack      = ($urandom_range(3) == 0);
      eoi          = ($urandom_range(5) == 0);
      clear_all    = ($urandom_range(31) == 0);
      if ($urandom_range(299) == 0) async_reset();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
